// File: rtl/notch_mc_scheduler_pkg.sv
// Shared constants and types for the multi-channel notch biquad scheduler.
// Coefficients are signed Q2.14.
package notch_pkg;

  localparam int STATE_WIDTH_DEF = 32;

  localparam logic signed [15:0] B0 = 16'sd15725;
  localparam logic signed [15:0] B1 = 16'sd25443;
  localparam logic signed [15:0] B2 = 16'sd15725;
  localparam logic signed [15:0] A1 = 16'sd25443;
  localparam logic signed [15:0] A2 = 16'sd15066;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_UPD  = 1'b1
  } state_t;

endpackage

// File: rtl/notch_mc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
// The pointer register lives in the parent.
module notch_rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [NUM_CH-1:0]         gnt_o,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx_o,
  output logic                      any_o
);

  localparam int IDXW = $clog2(NUM_CH);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = |req_i;
    idx       = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/notch_mc_scheduler.sv
// One transposed-DF-II notch biquad shared round-robin across NUM_CH channels,
// each channel keeping its own (s1, s2) context. Two cycles per sample.
module notch_mc_scheduler
  import notch_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int STATE_WIDTH = STATE_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  output logic [NUM_CH-1:0]            ch_ready_o,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [$clog2(NUM_CH)-1:0]    out_ch_o,
  output logic                         busy_o
);

  localparam int IDXW = $clog2(NUM_CH);

  localparam logic signed [STATE_WIDTH-1:0] B0_X = STATE_WIDTH'(B0);
  localparam logic signed [STATE_WIDTH-1:0] B1_X = STATE_WIDTH'(B1);
  localparam logic signed [STATE_WIDTH-1:0] B2_X = STATE_WIDTH'(B2);
  localparam logic signed [STATE_WIDTH-1:0] A1_X = STATE_WIDTH'(A1);
  localparam logic signed [STATE_WIDTH-1:0] A2_X = STATE_WIDTH'(A2);

  state_t                        state_q, state_d;
  logic [IDXW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]               ch_q, ch_d;
  logic signed [DATA_WIDTH-1:0]  x_q, x_d;
  logic signed [STATE_WIDTH-1:0] y_q, y_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic [IDXW-1:0]               out_ch_q, out_ch_d;

  logic signed [STATE_WIDTH-1:0] s1_q [NUM_CH];
  logic signed [STATE_WIDTH-1:0] s1_d [NUM_CH];
  logic signed [STATE_WIDTH-1:0] s2_q [NUM_CH];
  logic signed [STATE_WIDTH-1:0] s2_d [NUM_CH];

  logic [NUM_CH-1:0]             gnt;
  logic [IDXW-1:0]               gnt_idx;
  logic                          gnt_any;
  logic                          grant_en;

  logic signed [DATA_WIDTH-1:0]  gnt_x;
  logic signed [STATE_WIDTH-1:0] gnt_x_ext;
  logic signed [STATE_WIDTH-1:0] x_ext;
  logic signed [STATE_WIDTH-1:0] y_sh;
  logic signed [STATE_WIDTH-1:0] y_next;
  logic signed [STATE_WIDTH-1:0] s1_next;
  logic signed [STATE_WIDTH-1:0] s2_next;

  notch_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i     (ch_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // A flush cycle never grants, so flush and a new sample cannot collide.
  assign grant_en   = (state_q == S_IDLE) && !flush_i && gnt_any;
  assign ch_ready_o = grant_en ? gnt : '0;
  assign busy_o     = (state_q == S_UPD);

  assign gnt_x     = ch_data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_x_ext = STATE_WIDTH'(gnt_x);
  assign x_ext     = STATE_WIDTH'(x_q);
  assign y_sh      = y_q >>> 14;

  assign y_next  = gnt_x_ext * B0_X + s1_q[gnt_idx];
  assign s1_next = x_ext * B1_X - y_sh * A1_X + s2_q[ch_q];
  assign s2_next = x_ext * B2_X - y_sh * A2_X;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ch_d        = ch_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          x_d     = gnt_x;
          ch_d    = gnt_idx;
          y_d     = y_next;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        out_valid_d = 1'b1;
        out_data_d  = y_q[DATA_WIDTH+13:14];
        out_ch_d    = ch_q;
        rr_ptr_d    = (ch_q == IDXW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flush wins over the writeback of the channel being updated.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      s1_d[i] = s1_q[i];
      s2_d[i] = s2_q[i];
      if (flush_i) begin
        s1_d[i] = '0;
        s2_d[i] = '0;
      end else if ((state_q == S_UPD) && (ch_q == IDXW'(i))) begin
        s1_d[i] = s1_next;
        s2_d[i] = s2_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      ch_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ch_q        <= ch_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_q[i] <= s1_d[i];
        s2_q[i] <= s2_d[i];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_notch_mc_scheduler.sv
// Self-checking bench for notch_mc_scheduler: per-feature tasks plus a
// scoreboard that predicts each output at the handshake and compares on out_valid_o.
module tb_notch_mc_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;

  localparam logic signed [31:0] MB0 = 32'sd15725;
  localparam logic signed [31:0] MB1 = 32'sd25443;
  localparam logic signed [31:0] MB2 = 32'sd15725;
  localparam logic signed [31:0] MA1 = 32'sd25443;
  localparam logic signed [31:0] MA2 = 32'sd15066;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    ch_valid = '0;
  logic [N*DW-1:0] ch_data = '0;
  logic [N-1:0]    ch_ready_o;
  logic            flush = 1'b0;
  logic            out_valid_o;
  logic [DW-1:0]   out_data_o;
  logic [1:0]      out_ch_o;
  logic            busy_o;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  always #5 clk = ~clk;

  notch_mc_scheduler #(
    .NUM_CH      (N),
    .DATA_WIDTH  (DW),
    .STATE_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_valid_i  (ch_valid),
    .ch_data_i   (ch_data),
    .ch_ready_o  (ch_ready_o),
    .flush_i     (flush),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ch_o    (out_ch_o),
    .busy_o      (busy_o)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int          ch;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  logic signed [31:0] m_s1 [N];
  logic signed [31:0] m_s2 [N];
  logic               pend = 1'b0;
  int                 pch = 0;
  logic signed [31:0] ps1, ps2;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_s1[i] = '0;
      m_s2[i] = '0;
    end
  end

  // Inputs change just after posedge, so at negedge they show what the next edge will see.
  always @(negedge clk) begin
    exp_t               e;
    logic signed [15:0] xd;
    logic signed [31:0] xs, y, ysh;
    ncyc++;
    if (!rst_n) begin
      sb.delete();
      pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_s1[i] = '0;
        m_s2[i] = '0;
      end
    end else begin
      if (out_valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious: out_valid_o with nothing expected, got ch=%0d data=%0d", out_ch_o, out_data_o);
        end else begin
          e = sb.pop_front();
          $display("out ch=%0d data=%0d (expect ch=%0d data=%0d)", out_ch_o, $signed(out_data_o), e.ch, $signed(e.data));
          if (out_data_o !== e.data || int'(out_ch_o) != e.ch || ncyc != e.cyc)
            begin
              errors++;
              $display("FAIL sb_out: got ch=%0d data=%0d cyc=%0d, expected ch=%0d data=%0d cyc=%0d",
                       out_ch_o, $signed(out_data_o), ncyc, e.ch, $signed(e.data), e.cyc);
            end
        end
      end
      checks++;
      if (!$onehot0(ch_ready_o) || (busy_o && ch_ready_o != '0)) begin
        errors++;
        $display("FAIL ready_legal: got ch_ready_o=%b busy=%b, expected one-hot or zero and zero while busy",
                 ch_ready_o, busy_o);
      end
      if (pend) begin
        if (!flush) begin
          m_s1[pch] = ps1;
          m_s2[pch] = ps2;
        end
        pend = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < N; i++) begin
          m_s1[i] = '0;
          m_s2[i] = '0;
        end
      end
      for (int c = 0; c < N; c++) begin
        if (ch_valid[c] && ch_ready_o[c]) begin
          xd  = ch_data[c*DW +: DW];
          xs  = 32'(xd);
          y   = xs * MB0 + m_s1[c];
          ysh = y >>> 14;
          ps1 = xs * MB1 - ysh * MA1 + m_s2[c];
          ps2 = xs * MB2 - ysh * MA2;
          pch = c;
          pend = 1'b1;
          e.ch = c;
          e.data = y[29:14];
          e.cyc = ncyc + 2;
          sb.push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int c, input logic [15:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    ch_valid[c] = 1'b1;
    ch_data[c*DW +: DW] = d;
    forever begin
      @(negedge clk);
      if (ch_ready_o[c]) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: ch%0d never granted, got ch_ready_o=%b, expected bit %0d", c, ch_ready_o, c);
        break;
      end
    end
    @(posedge clk); #1;
    ch_valid[c] = 1'b0;
  endtask

  task automatic get_out(output int oc, output logic [15:0] od);
    int n;
    n = 0;
    oc = -1;
    od = '0;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid_o) begin
        oc = int'(out_ch_o);
        od = out_data_o;
        break;
      end
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: got no out_valid_o within 20 cycles, expected one pulse");
    end
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 16'd0 || out_ch_o !== 2'd0 || busy_o !== 1'b0 || ch_ready_o !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%0d ch=%0d busy=%b ready=%b, expected all zero",
               out_valid_o, out_data_o, out_ch_o, busy_o, ch_ready_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ch_ready_o !== 4'b0 || out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: got ready=%b valid=%b, expected 0000 and 0", ch_ready_o, out_valid_o);
      end
    end
  endtask

  task automatic test_impulse();
    int oc;
    logic [15:0] od;
    send(0, 16'd16384);
    get_out(oc, od);
    checks++;
    if (od !== 16'd15725 || oc != 0) begin
      errors++;
      $display("FAIL impulse_0: got ch=%0d data=%0d, expected ch=0 data=15725", oc, $signed(od));
    end
    send(0, 16'd0);
    get_out(oc, od);
    checks++;
    if (od !== 16'd1023 || oc != 0) begin
      errors++;
      $display("FAIL impulse_1: got ch=%0d data=%0d, expected ch=0 data=1023", oc, $signed(od));
    end
  endtask

  task automatic test_isolation();
    int oc;
    logic [15:0] od;
    flush_pulse();
    send(0, 16'd16384);
    get_out(oc, od);
    checks++;
    if (od !== 16'd15725 || oc != 0) begin
      errors++;
      $display("FAIL iso_ch0_a: got ch=%0d data=%0d, expected ch=0 data=15725", oc, $signed(od));
    end
    send(1, 16'd0);
    get_out(oc, od);
    checks++;
    if (od !== 16'd0 || oc != 1) begin
      errors++;
      $display("FAIL iso_ch1: got ch=%0d data=%0d, expected ch=1 data=0", oc, $signed(od));
    end
    send(0, 16'd0);
    get_out(oc, od);
    checks++;
    if (od !== 16'd1023 || oc != 0) begin
      errors++;
      $display("FAIL iso_ch0_b: got ch=%0d data=%0d, expected ch=0 data=1023", oc, $signed(od));
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    int k;
    k = 0;
    reset_pulse();
    ch_data = {16'd0, 16'd1000, 16'hE000, 16'd16384};
    ch_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_rdy = (i % 2 == 0) ? 4'(1 << ((i / 2) % 4)) : 4'b0000;
      checks++;
      if (ch_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL fair_ready[%0d]: got %b, expected %b", i, ch_ready_o, exp_rdy);
      end
      if (out_valid_o) begin
        checks++;
        if (int'(out_ch_o) != (k % 4)) begin
          errors++;
          $display("FAIL fair_out_ch[%0d]: got %0d, expected %0d", k, out_ch_o, k % 4);
        end
        k++;
      end
    end
    @(posedge clk); #1 ch_valid = 4'b0000;
    checks++;
    if (k != 5) begin
      errors++;
      $display("FAIL fair_count: got %0d outputs, expected 5", k);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush();
    int oc;
    logic [15:0] od;
    flush_pulse();
    send(0, 16'd16384);
    get_out(oc, od);
    checks++;
    if (od !== 16'd15725) begin
      errors++;
      $display("FAIL flush_pre: got %0d, expected 15725", $signed(od));
    end
    flush_pulse();
    send(0, 16'd0);
    get_out(oc, od);
    checks++;
    if (od !== 16'd0 || oc != 0) begin
      errors++;
      $display("FAIL flush_idle: got ch=%0d data=%0d, expected ch=0 data=0", oc, $signed(od));
    end
    // flush together with a valid request: no grant that cycle
    @(posedge clk); #1;
    flush = 1'b1;
    ch_data[0 +: DW] = 16'd16384;
    ch_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ch_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL flush_nogrant: got ready=%b, expected 0000", ch_ready_o);
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (ch_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL flush_regrant: got ready=%b, expected 0001", ch_ready_o);
    end
    @(posedge clk); #1 ch_valid[0] = 1'b0;
    get_out(oc, od);
    checks++;
    if (od !== 16'd15725) begin
      errors++;
      $display("FAIL flush_after: got %0d, expected 15725", $signed(od));
    end
    // flush during the update cycle: pulse still emitted, writeback discarded
    flush_pulse();
    send(0, 16'd16384);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    get_out(oc, od);
    checks++;
    if (od !== 16'd15725 || oc != 0) begin
      errors++;
      $display("FAIL flush_upd_out: got ch=%0d data=%0d, expected ch=0 data=15725", oc, $signed(od));
    end
    send(0, 16'd0);
    get_out(oc, od);
    checks++;
    if (od !== 16'd0) begin
      errors++;
      $display("FAIL flush_upd_ctx: got %0d, expected 0", $signed(od));
    end
  endtask

  task automatic test_reset_midop();
    int oc;
    logic [15:0] od;
    flush_pulse();
    send(0, 16'd16384);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy: got busy=%b, expected 1", busy_o);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL midop_quiet: got valid=%b busy=%b, expected 0 and 0", out_valid_o, busy_o);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(0, 16'd0);
    get_out(oc, od);
    checks++;
    if (od !== 16'd0 || oc != 0) begin
      errors++;
      $display("FAIL midop_after: got ch=%0d data=%0d, expected ch=0 data=0", oc, $signed(od));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_impulse();
    test_isolation();
    test_fairness();
    test_flush();
    test_reset_midop();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending outputs, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
